trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl_if.sv | 39 +++
 rtl/trap_ctrl.sv | 158 +++++++++++++++
 tb/tb_trap_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: bundles the exec-stage trap events, the CSR port and the fetch redirect handshake.
// Revision: 1.0
`default_nettype none

interface trap_ctrl_if #(
  parameter int XLEN    = 32,
  parameter int NUM_IRQ = 4
);
  logic                exc_valid;
  logic [4:0]          exc_cause;
  logic [XLEN-1:0]     exc_pc;
  logic [XLEN-1:0]     exc_tval;
  logic [NUM_IRQ-1:0]  irq;
  logic                boundary_valid;
  logic [XLEN-1:0]     boundary_pc;
  logic                mret_valid;
  logic                csr_we;
  logic [11:0]         csr_addr;
  logic [XLEN-1:0]     csr_wdata;
  logic [XLEN-1:0]     csr_rdata;
  logic                csr_illegal;
  logic                redirect_valid;
  logic [XLEN-1:0]     redirect_pc;
  logic                redirect_ready;

  modport master (
    output exc_valid, exc_cause, exc_pc, exc_tval, irq, boundary_valid, boundary_pc,
           mret_valid, csr_we, csr_addr, csr_wdata, redirect_ready,
    input  csr_rdata, csr_illegal, redirect_valid, redirect_pc
  );

  modport slave (
    input  exc_valid, exc_cause, exc_pc, exc_tval, irq, boundary_valid, boundary_pc,
           mret_valid, csr_we, csr_addr, csr_wdata, redirect_ready,
    output csr_rdata, csr_illegal, redirect_valid, redirect_pc
  );
endinterface

`default_nettype wire

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap CSRs, exception/interrupt/MRET sequencing and fetch redirect.
// Revision: 1.0
`default_nettype none

module trap_ctrl #(
  parameter int              XLEN           = 32,
  parameter int              NUM_IRQ        = 4,
  parameter int              IRQ_CAUSE_BASE = 16,
  parameter logic [XLEN-1:0] RESET_MTVEC    = '0
) (
  input  logic         clk,
  input  logic         rst,
  trap_ctrl_if.slave   bus
);

  localparam logic [0:0]      S_IDLE     = 1'b0;
  localparam logic [0:0]      S_REDIRECT = 1'b1;
  localparam logic [11:0]     A_MSTATUS  = 12'h300;
  localparam logic [11:0]     A_MIE      = 12'h304;
  localparam logic [11:0]     A_MTVEC    = 12'h305;
  localparam logic [11:0]     A_MSCRATCH = 12'h340;
  localparam logic [11:0]     A_MEPC     = 12'h341;
  localparam logic [11:0]     A_MCAUSE   = 12'h342;
  localparam logic [11:0]     A_MTVAL    = 12'h343;
  localparam logic [11:0]     A_MIP      = 12'h344;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [0:0]         state_q, state_d;
  logic               mst_mie_q, mst_mpie_q;
  logic [NUM_IRQ-1:0] mie_q;
  logic [XLEN-1:0]    mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, redirect_pc_q;

  logic [NUM_IRQ-1:0] irq_pend;
  logic               irq_hit;
  logic [3:0]         irq_idx;
  logic [XLEN-1:0]    irq_code, trap_base, int_target, csr_rdata;
  logic               in_idle, exc_take, mret_take, int_take, event_take;
  logic               csr_impl, csr_ro, csr_illegal, csr_wr, redirect_valid;

  // Scanning downward leaves the lowest pending index as the winner.
  always_comb begin
    irq_pend = bus.irq & mie_q;
    irq_hit  = 1'b0;
    irq_idx  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_pend[i]) begin
        irq_hit = 1'b1;
        irq_idx = 4'(i);
      end
    end
  end

  assign irq_code   = XLEN'(IRQ_CAUSE_BASE) + XLEN'(irq_idx);
  assign trap_base  = mtvec_q & ALIGN_MASK;
  assign int_target = (mtvec_q[1:0] == 2'b01) ? trap_base + (irq_code << 2) : trap_base;

  assign in_idle    = (state_q == S_IDLE);
  assign exc_take   = in_idle && bus.exc_valid;
  assign mret_take  = in_idle && !bus.exc_valid && bus.mret_valid;
  assign int_take   = in_idle && !bus.exc_valid && !bus.mret_valid && bus.boundary_valid
                      && mst_mie_q && irq_hit;
  assign event_take = exc_take || mret_take || int_take;

  always_comb begin
    csr_rdata = '0;
    csr_impl  = 1'b1;
    case (bus.csr_addr)
      A_MSTATUS: begin
        csr_rdata[3] = mst_mie_q;
        csr_rdata[7] = mst_mpie_q;
      end
      A_MIE:      csr_rdata[IRQ_CAUSE_BASE +: NUM_IRQ] = mie_q;
      A_MTVEC:    csr_rdata = mtvec_q;
      A_MSCRATCH: csr_rdata = mscratch_q;
      A_MEPC:     csr_rdata = mepc_q;
      A_MCAUSE:   csr_rdata = mcause_q;
      A_MTVAL:    csr_rdata = mtval_q;
      A_MIP:      csr_rdata[IRQ_CAUSE_BASE +: NUM_IRQ] = bus.irq;
      default:    csr_impl = 1'b0;
    endcase
  end

  assign csr_ro      = (bus.csr_addr[11:10] == 2'b11) || (bus.csr_addr == A_MIP);
  assign csr_illegal = !csr_impl || (bus.csr_we && csr_ro);
  assign csr_wr      = in_idle && !event_take && bus.csr_we && !csr_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (event_take) state_d = S_REDIRECT;
      S_REDIRECT: if (bus.redirect_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    redirect_valid = (state_q == S_REDIRECT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mst_mie_q     <= 1'b0;
      mst_mpie_q    <= 1'b0;
      mie_q         <= '0;
      mtvec_q       <= RESET_MTVEC;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      redirect_pc_q <= '0;
    end else if (exc_take) begin
      mepc_q        <= bus.exc_pc & ALIGN_MASK;
      mcause_q      <= XLEN'(bus.exc_cause);
      mtval_q       <= bus.exc_tval;
      mst_mpie_q    <= mst_mie_q;
      mst_mie_q     <= 1'b0;
      redirect_pc_q <= trap_base;
    end else if (mret_take) begin
      mst_mie_q     <= mst_mpie_q;
      mst_mpie_q    <= 1'b1;
      redirect_pc_q <= mepc_q;
    end else if (int_take) begin
      mepc_q        <= bus.boundary_pc & ALIGN_MASK;
      mcause_q      <= {1'b1, irq_code[XLEN-2:0]};
      mtval_q       <= '0;
      mst_mpie_q    <= mst_mie_q;
      mst_mie_q     <= 1'b0;
      redirect_pc_q <= int_target;
    end else if (csr_wr) begin
      case (bus.csr_addr)
        A_MSTATUS: begin
          mst_mie_q  <= bus.csr_wdata[3];
          mst_mpie_q <= bus.csr_wdata[7];
        end
        A_MIE:      mie_q      <= bus.csr_wdata[IRQ_CAUSE_BASE +: NUM_IRQ];
        A_MTVEC:    mtvec_q    <= bus.csr_wdata;
        A_MSCRATCH: mscratch_q <= bus.csr_wdata;
        A_MEPC:     mepc_q     <= bus.csr_wdata & ALIGN_MASK;
        A_MCAUSE:   mcause_q   <= bus.csr_wdata;
        A_MTVAL:    mtval_q    <= bus.csr_wdata;
        default:    ;
      endcase
    end
  end

  assign bus.csr_rdata      = csr_rdata;
  assign bus.csr_illegal    = csr_illegal;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed vectors; redirect targets are scoreboarded and checked by a handshake monitor.
// Revision: 1.0
`default_nettype none

module tb_trap_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   n_push = 0;
  int   n_seen = 0;
  logic [31:0] exp_q[$];

  trap_ctrl_if #(.XLEN(32), .NUM_IRQ(4)) bus ();

  trap_ctrl #(
    .XLEN(32), .NUM_IRQ(4), .IRQ_CAUSE_BASE(16), .RESET_MTVEC(32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted redirect must match the oldest expected target.
  always @(negedge clk) begin
    if (!rst && bus.redirect_valid === 1'b1 && bus.redirect_ready === 1'b1) begin
      n_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_redirect", bus.redirect_pc, 32'hxxxx_xxxx);
      end else begin
        chk("redirect_pc", bus.redirect_pc, exp_q.pop_front());
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    bus.csr_we   = 1'b0;
    bus.csr_addr = a;
    #1;
    chk(name, bus.csr_rdata, exp);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic exp_ill);
    sync();
    bus.csr_we    = 1'b1;
    bus.csr_addr  = a;
    bus.csr_wdata = d;
    #1;
    chk("csr_illegal_on_write", {31'b0, bus.csr_illegal}, {31'b0, exp_ill});
    sync();
    bus.csr_we = 1'b0;
  endtask

  // Caller has driven the event inputs at posedge+1; they are held for one edge.
  task automatic fire(input logic [31:0] exp_pc);
    bit done;
    exp_q.push_back(exp_pc);
    n_push++;
    sync();
    bus.exc_valid      = 1'b0;
    bus.mret_valid     = 1'b0;
    bus.boundary_valid = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.redirect_valid === 1'b0) begin
        done = 1'b1;
        break;
      end
      sync();
    end
    if (!done) chk("redirect_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    bus.exc_valid = 0; bus.exc_cause = 0; bus.exc_pc = 0; bus.exc_tval = 0;
    bus.irq = 0; bus.boundary_valid = 0; bus.boundary_pc = 0; bus.mret_valid = 0;
    bus.csr_we = 0; bus.csr_addr = 12'h300; bus.csr_wdata = 0; bus.redirect_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_redirect_valid", {31'b0, bus.redirect_valid}, 32'd0);
    chk("reset_redirect_pc", bus.redirect_pc, 32'd0);
    rst = 1'b0;
    rd("reset_mstatus", 12'h300, 32'h0);
    chk("mstatus_legal", {31'b0, bus.csr_illegal}, 32'd0);
    rd("reset_mie", 12'h304, 32'h0);
    rd("reset_mtvec", 12'h305, 32'h0);
    rd("reset_mepc", 12'h341, 32'h0);
    rd("reset_mcause", 12'h342, 32'h0);

    // Direct-mode exception entry.
    wr(12'h305, 32'h30, 1'b0);
    wr(12'h300, 32'h8, 1'b0);
    sync();
    bus.exc_valid = 1; bus.exc_cause = 5'd2; bus.exc_pc = 32'h14; bus.exc_tval = 32'hF11FD073;
    fire(32'h30);
    rd("exc_mepc", 12'h341, 32'h14);
    rd("exc_mcause", 12'h342, 32'h2);
    rd("exc_mtval", 12'h343, 32'hF11FD073);
    rd("exc_mstatus", 12'h300, 32'h80);

    // Vectored interrupt; irq[1] beats irq[2].
    wr(12'h304, 32'h0006_0000, 1'b0);
    wr(12'h305, 32'h101, 1'b0);
    wr(12'h300, 32'h8, 1'b0);
    bus.irq = 4'b0110;
    rd("mip_read", 12'h344, 32'h0006_0000);
    sync();
    bus.boundary_valid = 1; bus.boundary_pc = 32'h40;
    fire(32'h144);
    bus.irq = 4'b0000;
    rd("int_mcause", 12'h342, 32'h8000_0011);
    rd("int_mepc", 12'h341, 32'h40);
    rd("int_mtval", 12'h343, 32'h0);
    rd("int_mstatus", 12'h300, 32'h80);

    // Exception wins over a simultaneous interrupt; the interrupt follows MRET.
    wr(12'h304, 32'h0001_0000, 1'b0);
    wr(12'h300, 32'h8, 1'b0);
    sync();
    bus.exc_valid = 1; bus.exc_cause = 5'd3; bus.exc_pc = 32'h50; bus.exc_tval = 32'h0;
    bus.irq = 4'b0001; bus.boundary_valid = 1; bus.boundary_pc = 32'h90;
    fire(32'h100);
    rd("prio_mcause", 12'h342, 32'h3);
    rd("prio_mepc", 12'h341, 32'h50);
    sync();
    bus.mret_valid = 1;
    fire(32'h50);
    rd("mret_mstatus", 12'h300, 32'h88);
    sync();
    bus.boundary_valid = 1; bus.boundary_pc = 32'h60;
    fire(32'h140);
    bus.irq = 4'b0000;
    rd("late_int_mcause", 12'h342, 32'h8000_0010);
    rd("late_int_mepc", 12'h341, 32'h60);

    // mepc alignment and MRET restoring a cleared MPIE.
    wr(12'h341, 32'h3E, 1'b0);
    rd("mepc_align", 12'h341, 32'h3C);
    wr(12'h300, 32'h8, 1'b0);
    sync();
    bus.mret_valid = 1;
    fire(32'h3C);
    rd("mret2_mstatus", 12'h300, 32'h80);

    // Illegal and read-only accesses.
    wr(12'h300, 32'hFFFF_FF77, 1'b0);
    rd("mstatus_mask", 12'h300, 32'h0);
    wr(12'hF11, 32'h1234, 1'b1);
    rd("f11_read", 12'hF11, 32'h0);
    chk("f11_illegal", {31'b0, bus.csr_illegal}, 32'd1);
    bus.irq = 4'b0001;
    wr(12'h344, 32'hFFFF_FFFF, 1'b1);
    rd("mip_unchanged", 12'h344, 32'h0001_0000);
    wr(12'h7C0, 32'h5, 1'b1);
    wr(12'h340, 32'hDEAD_BEEF, 1'b0);
    rd("mscratch", 12'h340, 32'hDEAD_BEEF);
    bus.irq = 4'b0000;

    // Stalled redirect ignores new events and CSR writes, then an async reset cancels it.
    wr(12'h305, 32'h30, 1'b0);
    bus.redirect_ready = 0;
    sync();
    bus.exc_valid = 1; bus.exc_cause = 5'd2; bus.exc_pc = 32'h70; bus.exc_tval = 32'h1;
    exp_q.push_back(32'h30);
    n_push++;
    sync();
    for (int c = 0; c < 5; c++) begin
      bus.exc_valid = 1; bus.exc_cause = 5'd5; bus.exc_pc = 32'hAA0;
      bus.csr_we = 1; bus.csr_addr = 12'h340; bus.csr_wdata = 32'h1234_5678;
      #1;
      chk("stall_valid", {31'b0, bus.redirect_valid}, 32'd1);
      chk("stall_pc", bus.redirect_pc, 32'h30);
      sync();
    end
    bus.exc_valid = 0; bus.csr_we = 0;
    rd("stall_mepc", 12'h341, 32'h70);
    rd("stall_mscratch", 12'h340, 32'hDEAD_BEEF);
    rd("stall_mcause", 12'h342, 32'h2);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, bus.redirect_valid}, 32'd0);
    n_push -= exp_q.size();
    exp_q.delete();
    rd("rst_mscratch", 12'h340, 32'h0);
    rd("rst_mepc", 12'h341, 32'h0);
    rd("rst_mtvec", 12'h305, 32'h0);
    rd("rst_mstatus", 12'h300, 32'h0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'h0);
    sync();
    rst = 1'b0;
    bus.redirect_ready = 1;

    sync();
    bus.exc_valid = 1; bus.exc_cause = 5'd2; bus.exc_pc = 32'h80; bus.exc_tval = 32'h0;
    fire(32'h0);
    rd("post_rst_mepc", 12'h341, 32'h80);

    repeat (2) sync();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("redirect_count", n_seen, n_push);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
